// File: rtl/biriscv_alu_pipe_pkg.sv
// Opcode map and shared helpers for the pipelined biRISC-V integer ALU.
package biriscv_alu_pipe_pkg;

    localparam int ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_NONE = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SHL  = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SHR  = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 5'd10;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'd11;
    localparam logic [ALU_OP_W-1:0] ALU_ROL  = 5'd12;
    localparam logic [ALU_OP_W-1:0] ALU_ROR  = 5'd13;
    localparam logic [ALU_OP_W-1:0] ALU_MIN  = 5'd14;
    localparam logic [ALU_OP_W-1:0] ALU_MAX  = 5'd15;
    localparam logic [ALU_OP_W-1:0] ALU_MINU = 5'd16;
    localparam logic [ALU_OP_W-1:0] ALU_MAXU = 5'd17;
    localparam logic [ALU_OP_W-1:0] ALU_ANDN = 5'd18;
    localparam logic [ALU_OP_W-1:0] ALU_ORN  = 5'd19;
    localparam logic [ALU_OP_W-1:0] ALU_XNOR = 5'd20;

    // Opcode 5 is a hole in the map; everything past XNOR is unassigned.
    function automatic logic alu_op_illegal(input logic [ALU_OP_W-1:0] op);
        return (op == 5'd5) || (op > ALU_XNOR);
    endfunction

endpackage

// File: rtl/biriscv_alu_core.sv
// Purely combinational XLEN-wide ALU: base RV integer ops plus Zbb rotate/min/max/logic-not.
module biriscv_alu_core
    import biriscv_alu_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [XLEN-1:0]     result_o,
    output logic                illegal_o
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    logic [SH_W:0]   rot_inv;
    logic            lt_s;
    logic            lt_u;

    // rot_inv equals XLEN for a zero amount, so the wrap-around term shifts out to 0.
    assign shamt   = b_i[SH_W-1:0];
    assign rot_inv = (SH_W+1)'(XLEN) - {1'b0, shamt};
    assign lt_s    = $signed(a_i) < $signed(b_i);
    assign lt_u    = a_i < b_i;

    // NOTE: every output gets a default before the case, so no latch can be inferred.
    always_comb begin
        result_o  = a_i;
        illegal_o = alu_op_illegal(op_i);
        case (op_i)
            ALU_SHL:  result_o = a_i << shamt;
            ALU_SHR:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $signed(a_i) >>> shamt;
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_ROL:  result_o = (a_i << shamt) | (a_i >> rot_inv);
            ALU_ROR:  result_o = (a_i >> shamt) | (a_i << rot_inv);
            ALU_MIN:  result_o = lt_s ? a_i : b_i;
            ALU_MAX:  result_o = lt_s ? b_i : a_i;
            ALU_MINU: result_o = lt_u ? a_i : b_i;
            ALU_MAXU: result_o = lt_u ? b_i : a_i;
            ALU_ANDN: result_o = a_i & ~b_i;
            ALU_ORN:  result_o = a_i | ~b_i;
            ALU_XNOR: result_o = ~(a_i ^ b_i);
            default:  result_o = a_i;
        endcase
    end

endmodule

// File: rtl/biriscv_alu_pipe.sv
// Pipelined ALU wrapper: STAGES register stages with valid/ready backpressure, flush and tag passthrough.
module biriscv_alu_pipe
    import biriscv_alu_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [ALU_OP_W-1:0] in_op_i,
    input  logic [XLEN-1:0]     in_a_i,
    input  logic [XLEN-1:0]     in_b_i,
    input  logic [TAG_W-1:0]    in_tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     out_result_o,
    output logic [TAG_W-1:0]    out_tag_o,
    output logic                out_illegal_o
);
    // With one stage the result is computed from the inputs; otherwise stage 1 holds operands.
    localparam int FIRST_RES = (STAGES == 1) ? 0 : 1;
    localparam int NRES      = STAGES - FIRST_RES;

    logic [STAGES-1:0] valid_q, valid_d, adv, fill;
    logic [STAGES:0]   take;
    logic              accept;

    // take[i]: stage i can load this cycle; computed from the output end backwards.
    always_comb begin
        take         = '0;
        adv          = '0;
        take[STAGES] = out_ready_i;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i]  = valid_q[i] && take[i+1];
            take[i] = !valid_q[i] || adv[i];
        end
    end

    // Flush drops whatever is accepted alongside it, so the input may stay open.
    assign in_ready_o = take[0] || flush_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        fill    = '0;
        fill[0] = accept;
        for (int i = 1; i < STAGES; i++) fill[i] = adv[i-1];
        for (int i = 0; i < STAGES; i++) valid_d[i] = fill[i] || (valid_q[i] && !adv[i]);
        if (flush_i) valid_d = '0;
    end

    // NOTE: state registers update with non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) valid_q <= '0;
        else         valid_q <= valid_d;
    end

    logic [ALU_OP_W-1:0] core_op;
    logic [XLEN-1:0]     core_a, core_b, core_res;
    logic [TAG_W-1:0]    core_tag;
    logic                core_ill;

    if (STAGES == 1) begin : g_direct
        assign core_op  = in_op_i;
        assign core_a   = in_a_i;
        assign core_b   = in_b_i;
        assign core_tag = in_tag_i;
    end else begin : g_opnd
        logic [ALU_OP_W-1:0] op_q;
        logic [XLEN-1:0]     a_q, b_q;
        logic [TAG_W-1:0]    tag_q;

        // NOTE: operand registers are left unreset; valid_q alone says whether they mean anything.
        always_ff @(posedge clk_i) begin
            if (fill[0]) begin
                op_q  <= in_op_i;
                a_q   <= in_a_i;
                b_q   <= in_b_i;
                tag_q <= in_tag_i;
            end
        end

        assign core_op  = op_q;
        assign core_a   = a_q;
        assign core_b   = b_q;
        assign core_tag = tag_q;
    end

    biriscv_alu_core #(.XLEN(XLEN)) u_core (
        .op_i      (core_op),
        .a_i       (core_a),
        .b_i       (core_b),
        .result_o  (core_res),
        .illegal_o (core_ill)
    );

    logic [XLEN-1:0]  res_q   [NRES];
    logic [XLEN-1:0]  res_src [NRES];
    logic [TAG_W-1:0] tag_q   [NRES];
    logic [TAG_W-1:0] tag_src [NRES];
    logic [NRES-1:0]  ill_q, ill_src;

    always_comb begin
        res_src[0] = core_res;
        tag_src[0] = core_tag;
        ill_src    = '0;
        ill_src[0] = core_ill;
        for (int j = 1; j < NRES; j++) begin
            res_src[j] = res_q[j-1];
            tag_src[j] = tag_q[j-1];
            ill_src[j] = ill_q[j-1];
        end
    end

    // Result chain is reset so the output fields read zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ill_q <= '0;
            for (int j = 0; j < NRES; j++) begin
                res_q[j] <= '0;
                tag_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NRES; j++) begin
                if (fill[FIRST_RES+j]) begin
                    res_q[j] <= res_src[j];
                    tag_q[j] <= tag_src[j];
                    ill_q[j] <= ill_src[j];
                end
            end
        end
    end

    assign out_valid_o   = valid_q[STAGES-1];
    assign out_result_o  = res_q[NRES-1];
    assign out_tag_o     = tag_q[NRES-1];
    assign out_illegal_o = ill_q[NRES-1];

endmodule

// File: tb/tb_biriscv_alu_pipe.sv
// Directed bench: a 32-bit/2-stage instance for function and handshake, a 64-bit/4-stage one for width and reset.
module tb_biriscv_alu_pipe;
    import biriscv_alu_pipe_pkg::*;

    logic clk;
    int   vectors;
    int   miscompares;

    logic        a_rst_n, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [4:0]  a_in_op, a_in_tag, a_out_tag;
    logic [31:0] a_in_a, a_in_b, a_out_result;

    logic        b_rst_n, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [4:0]  b_in_op, b_in_tag, b_out_tag;
    logic [63:0] b_in_a, b_in_b, b_out_result;

    biriscv_alu_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut_a (
        .clk_i(clk), .rst_ni(a_rst_n), .flush_i(a_flush),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_op_i(a_in_op),
        .in_a_i(a_in_a), .in_b_i(a_in_b), .in_tag_i(a_in_tag),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_result_o(a_out_result),
        .out_tag_o(a_out_tag), .out_illegal_o(a_out_illegal)
    );

    biriscv_alu_pipe #(.XLEN(64), .STAGES(4), .TAG_W(5)) dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .flush_i(b_flush),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_op_i(b_in_op),
        .in_a_i(b_in_a), .in_b_i(b_in_b), .in_tag_i(b_in_tag),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_result_o(b_out_result),
        .out_tag_o(b_out_tag), .out_illegal_o(b_out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag);
        a_in_valid = 1'b1;
        a_in_op    = op;
        a_in_a     = a;
        a_in_b     = b;
        a_in_tag   = tag;
    endtask

    task automatic check_a_out(input string tag, input logic [31:0] res, input logic [4:0] t,
                               input logic ill);
        check({tag, "_valid"}, 64'(a_out_valid), 64'd1);
        check({tag, "_result"}, 64'(a_out_result), 64'(res));
        check({tag, "_tag"}, 64'(a_out_tag), 64'(t));
        check({tag, "_illegal"}, 64'(a_out_illegal), 64'(ill));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        a_rst_n = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_in_op = '0; a_in_a = '0; a_in_b = '0; a_in_tag = '0;
        b_rst_n = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_op = '0; b_in_a = '0; b_in_b = '0; b_in_tag = '0;

        tbl[0]  = '{ALU_SHR,  32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 1'b0};
        tbl[1]  = '{ALU_SHL,  32'h0000_0001, 32'hFFFF_FFE1, 32'h0000_0002, 1'b0};
        tbl[2]  = '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        tbl[3]  = '{ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0};
        tbl[4]  = '{ALU_OR,   32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0};
        tbl[5]  = '{ALU_XOR,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0};
        tbl[6]  = '{ALU_ROL,  32'h8000_0001, 32'h0000_0020, 32'h8000_0001, 1'b0};
        tbl[7]  = '{ALU_ROL,  32'h8000_0001, 32'h0000_0001, 32'h0000_0003, 1'b0};
        tbl[8]  = '{ALU_MAX,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        tbl[9]  = '{ALU_MINU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        tbl[10] = '{ALU_ANDN, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0};
        tbl[11] = '{ALU_ORN,  32'h0000_0000, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0};
        tbl[12] = '{ALU_NONE, 32'hDEAD_BEEF, 32'h0000_1111, 32'hDEAD_BEEF, 1'b0};
        tbl[13] = '{5'd5,     32'h0000_ABCD, 32'h0000_0001, 32'h0000_ABCD, 1'b1};
        tbl[14] = '{5'd31,    32'h1234_5678, 32'h0000_0003, 32'h1234_5678, 1'b1};

        // Reset values, both instances.
        #2;
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        #1;
        check("a_rst_valid",   64'(a_out_valid),   64'd0);
        check("a_rst_result",  64'(a_out_result),  64'd0);
        check("a_rst_tag",     64'(a_out_tag),     64'd0);
        check("a_rst_illegal", 64'(a_out_illegal), 64'd0);
        check("b_rst_valid",   64'(b_out_valid),   64'd0);
        check("b_rst_result",  b_out_result,       64'd0);
        step();
        step();
        a_rst_n = 1'b1;
        #1;
        check("a_ready_after_rst", 64'(a_in_ready), 64'd1);

        // Single ADD with wrap, 2-stage latency.
        a_out_ready = 1'b1;
        drive_a(ALU_ADD, 32'hFFFF_FFFF, 32'd2, 5'd3);
        step();
        a_in_valid = 1'b0;
        check("t1_not_yet", 64'(a_out_valid), 64'd0);
        step();
        check_a_out("t1_add", 32'h0000_0001, 5'd3, 1'b0);
        step();
        check("t1_drained", 64'(a_out_valid), 64'd0);

        // Back-to-back stream at full throughput.
        drive_a(ALU_SRA, 32'h8000_0000, 32'h0000_0021, 5'd4);
        step();
        check("t2_ready0", 64'(a_in_ready), 64'd1);
        drive_a(ALU_ROR, 32'h0000_0001, 32'h0000_0001, 5'd5);
        step();
        check_a_out("t2_sra", 32'hC000_0000, 5'd4, 1'b0);
        drive_a(ALU_MIN, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6);
        step();
        check_a_out("t2_ror", 32'h8000_0000, 5'd5, 1'b0);
        a_in_valid = 1'b0;
        step();
        check_a_out("t2_min", 32'hFFFF_FFFF, 5'd6, 1'b0);
        step();
        check("t2_drained", 64'(a_out_valid), 64'd0);

        // Backpressure: consumer stalls for five cycles while four ops are offered.
        a_out_ready = 1'b0;
        drive_a(ALU_SLT, 32'hFFFF_FFFE, 32'h0000_0001, 5'd1);
        step();
        drive_a(ALU_SLTU, 32'hFFFF_FFFE, 32'h0000_0001, 5'd2);
        step();
        check_a_out("t3_stall_slt", 32'h0000_0001, 5'd1, 1'b0);
        drive_a(ALU_MAXU, 32'hFFFF_FFFE, 32'h0000_0001, 5'd3);
        #1;
        check("t3_ready_low", 64'(a_in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t3_hold_valid",  64'(a_out_valid),  64'd1);
            check("t3_hold_result", 64'(a_out_result), 64'd1);
            check("t3_hold_tag",    64'(a_out_tag),    64'd1);
            check("t3_hold_ready",  64'(a_in_ready),   64'd0);
        end
        a_out_ready = 1'b1;
        #1;
        check("t3_ready_release", 64'(a_in_ready), 64'd1);
        step();
        check_a_out("t3_sltu", 32'h0000_0000, 5'd2, 1'b0);
        drive_a(ALU_XNOR, 32'h0000_0000, 32'hFFFF_FFFF, 5'd4);
        step();
        check_a_out("t3_maxu", 32'hFFFF_FFFE, 5'd3, 1'b0);
        a_in_valid = 1'b0;
        step();
        check_a_out("t3_xnor", 32'h0000_0000, 5'd4, 1'b0);
        step();
        check("t3_drained", 64'(a_out_valid), 64'd0);

        // Flush with a full pipe plus a simultaneous accept.
        a_out_ready = 1'b0;
        drive_a(ALU_AND, 32'h0000_00F0, 32'h0000_003C, 5'd10);
        step();
        drive_a(ALU_OR, 32'h0000_00F0, 32'h0000_003C, 5'd11);
        step();
        drive_a(ALU_XOR, 32'h0000_00F0, 32'h0000_003C, 5'd12);
        a_flush = 1'b1;
        #1;
        check("t4_ready_in_flush", 64'(a_in_ready), 64'd1);
        step();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        check("t4_valid_after_flush", 64'(a_out_valid), 64'd0);
        a_out_ready = 1'b1;
        drive_a(ALU_ADD, 32'd5, 32'd7, 5'd9);
        step();
        a_in_valid = 1'b0;
        check("t4_no_ghost", 64'(a_out_valid), 64'd0);
        step();
        check_a_out("t4_add", 32'h0000_000C, 5'd9, 1'b0);
        step();
        check("t4_drained", 64'(a_out_valid), 64'd0);

        // Directed op table streamed back-to-back, including undefined opcodes.
        for (int i = 0; i <= 15; i++) begin
            if (i < 15) drive_a(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i));
            else        a_in_valid = 1'b0;
            step();
            if (i >= 1) check_a_out($sformatf("tbl%0d", i - 1), tbl[i-1].res, 5'(i - 1), tbl[i-1].ill);
        end
        step();
        check("tbl_drained", 64'(a_out_valid), 64'd0);

        // 64-bit, 4-stage instance: wide shift, then reset mid-flight.
        b_rst_n = 1'b1;
        #1;
        check("b_ready_after_rst", 64'(b_in_ready), 64'd1);
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_op     = ALU_SHL;
        b_in_a      = 64'd1;
        b_in_b      = 64'd63;
        b_in_tag    = 5'h1A;
        step();
        b_in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("t6_latency_e%0d", k), 64'(b_out_valid), 64'd0);
            step();
        end
        check("t6_valid",   64'(b_out_valid),   64'd1);
        check("t6_result",  b_out_result,       64'h8000_0000_0000_0000);
        check("t6_tag",     64'(b_out_tag),     64'h1A);
        check("t6_illegal", 64'(b_out_illegal), 64'd0);
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_op     = ALU_ADD;
        b_in_a      = 64'd1;
        b_in_b      = 64'd1;
        b_in_tag    = 5'h05;
        step();
        b_in_valid = 1'b0;
        b_rst_n    = 1'b0;
        #1;
        check("t6_rst_valid",   64'(b_out_valid),   64'd0);
        check("t6_rst_result",  b_out_result,       64'd0);
        check("t6_rst_tag",     64'(b_out_tag),     64'd0);
        check("t6_rst_illegal", 64'(b_out_illegal), 64'd0);
        step();
        b_rst_n     = 1'b1;
        b_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("t6_no_pulse_%0d", k), 64'(b_out_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/biriscv_alu_pipe.md
Name: biriscv_alu_pipe

Overview:
- Parametrised, pipelined integer ALU for the biRISC-V execute path.
- Generalises the fixed 32-bit two-register ALU:
  - XLEN-wide datapath.
  - Configurable pipeline depth.
  - valid/ready handshake with backpressure, pipeline flush and an opaque tag passthrough.
  - Zbb-style ops added: rotate, min/max, andn/orn/xnor.
- Sits between issue and writeback; the tag carries the destination/ROB id.

Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.
- STAGES, 2, register stages from accept to result; legal 1..4.
- TAG_W, 5, width of the sideband tag carried alongside each operation.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active-low.
- flush_i  in  1  kill every in-flight operation.
- in_valid_i  in  1  operation offered.
- in_ready_o  out  1  operation accepted when in_valid_i && in_ready_o.
- in_op_i  in  5  opcode (see Behaviour).
- in_a_i  in  XLEN  operand A.
- in_b_i  in  XLEN  operand B.
- in_tag_i  in  TAG_W  sideband tag.
- out_valid_o  out  1  result available.
- out_ready_i  in  1  consumer accepts when out_valid_o && out_ready_i.
- out_result_o  out  XLEN  result.
- out_tag_o  out  TAG_W  tag of the accepted operation.
- out_illegal_o  out  1  opcode was undefined.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - All stage valid bits clear.
  - out_valid_o=0, out_result_o=0, out_tag_o=0, out_illegal_o=0.
  - in_ready_o=1 once reset deasserts.
- Opcodes:
  - 0 NONE (result=A), 1 SHL, 2 SHR, 3 SRA, 4 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR.
  - 10 SLTU, 11 SLT, 12 ROL, 13 ROR, 14 MIN, 15 MAX, 16 MINU, 17 MAXU.
  - 18 ANDN (A & ~B), 19 ORN (A | ~B), 20 XNOR.
  - Any other value: result=A, out_illegal_o=1.
- Arithmetic and width rules:
  - Shift/rotate amount = B[log2(XLEN)-1:0]; upper bits of B are ignored.
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT/SLTU return 1 or 0, zero-extended to XLEN.
  - SLT and MIN/MAX are signed two's complement; MINU/MAXU and SLTU are unsigned.
  - ROL/ROR by 0 return A unchanged.
- Pipeline:
  - Stage 1 registers op/A/B/tag on accept.
  - Combinational evaluation happens between stage 1 and stage 2.
  - Stages 3..STAGES are pure delay registers for result, tag and illegal.
  - With STAGES=1 the result is computed from the inputs and registered in stage 1.
  - Latency: an op accepted at edge N presents out_valid_o at edge N+STAGES, provided there is no backpressure.
- Handshake:
  - A stage advances when its successor is empty or is advancing.
  - The last stage advances on out_ready_i.
  - in_ready_o = !stage1_valid || stage1_advances, with a combinational path from out_ready_i. This gives full throughput: one op per cycle with out_ready_i held high.
  - While out_valid_o=1 and out_ready_i=0:
    - out_result_o, out_tag_o and out_illegal_o hold stable.
    - out_valid_o stays high.
  - No bubbles are inserted: a full pipe of STAGES ops drains in STAGES consecutive cycles when out_ready_i is high.
- Flush:
  - flush_i=1 at an edge clears all stage valid bits, including an op being accepted in that same cycle (that op is dropped).
  - out_valid_o=0 on the following cycle.
  - in_ready_o stays 1 during flush.
  - An output handshake completing in the flush cycle counts as delivered.
- Reset mid-operation: all in-flight ops are lost; no output pulse.
- Data registers carry no reset requirement beyond the output fields listed above. Invalid stages must never drive out_valid_o.

Decomposition:
- Shared package/defines:
  - Opcode constants (ALU_* 5-bit values above).
  - Opcode width (5).
  - Illegal-op detection helper.
- One sub-module, biriscv_alu_core:
  - Purely combinational, parametrised by XLEN.
  - Inputs op/A/B; outputs result and illegal.
- biriscv_alu_pipe owns the stage registers, handshake and flush.

Test Plan:
1. STAGES=2, XLEN=32, ADD A=0xFFFF_FFFF B=2, tag=3, out_ready_i=1 -> out_valid_o exactly 2 cycles after accept, result=0x0000_0001, tag=3, illegal=0.
2. Back-to-back stream of SRA A=0x8000_0000 B=0x21, then ROR A=0x0000_0001 B=1, then MIN A=0xFFFF_FFFF B=1 -> results 0xC000_0000, 0x8000_0000, 0xFFFF_FFFF in consecutive cycles, one op per cycle.
3. Backpressure with out_ready_i=0 for 5 cycles while issuing 4 ops (SLT 0xFFFF_FFFE<1, SLTU same operands, MAXU, XNOR) -> in_ready_o drops after STAGES ops accepted; out_result_o stable while stalled; on release, results 1, 0, 0xFFFF_FFFE, 0x0000_0000 (XNOR of A=0 with B=0xFFFF_FFFF) emerge in order, with no loss or duplication.
4. Flush with 2 ops in flight plus a simultaneous accept -> none of the 3 appears; out_valid_o=0 next cycle; an ADD issued the cycle after flush returns normally.
5. Opcode 31, A=0x1234_5678 -> result 0x1234_5678, out_illegal_o=1.
6. XLEN=64, STAGES=4, SHL A=1 B=63 -> result 0x8000_0000_0000_0000 after 4 cycles; then assert rst_ni low mid-flight -> out_valid_o=0 immediately, all outputs zero.
